// File: rtl/iir_pkg.sv
// -----------------------------------------------------------------------------
// iir_pkg
// Shared definitions for the multi-channel second-order-section IIR cascade:
//   - iir_state_e : sequencer states (IDLE, MAC, SAT, OUT)
//   - TERM_*      : coefficient term index within a section (b0,b1,b2,a1,a2)
//   - NTERM       : number of coefficient terms per section
//   - ACC_W       : accumulator width
// -----------------------------------------------------------------------------
package iir_pkg;

  localparam int ACC_W = 48;
  localparam int NTERM = 5;

  localparam logic [2:0] TERM_B0 = 3'd0;
  localparam logic [2:0] TERM_B1 = 3'd1;
  localparam logic [2:0] TERM_B2 = 3'd2;
  localparam logic [2:0] TERM_A1 = 3'd3;
  localparam logic [2:0] TERM_A2 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_SAT  = 2'd2,
    ST_OUT  = 2'd3
  } iir_state_e;

endpackage

// File: rtl/iir_mac.sv
// -----------------------------------------------------------------------------
// iir_mac
// Single shared multiplier with a registered accumulator.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : update the accumulator this cycle
//   load       : replace accumulator with the new term (else add to it)
//   sub        : negate the product before load/accumulate (feedback terms)
//   din, coef  : signed multiplier operands
//   acc        : signed accumulator, full-precision products
// -----------------------------------------------------------------------------
module iir_mac
  import iir_pkg::*;
#(
  parameter int DATA_W = 25,
  parameter int COEF_W = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     load,
  input  logic                     sub,
  input  logic signed [DATA_W-1:0] din,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]  term_p0;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_p1;

  // Stage p0: product, sign extension, optional negation
  always_comb begin
    prod_p0 = din * coef;
    term_p0 = {{(ACC_W-PROD_W){prod_p0[PROD_W-1]}}, prod_p0};
    if (sub) begin
      term_p0 = -term_p0;
    end
    acc_d = acc_p1;
    if (en) begin
      acc_d = load ? term_p0 : (acc_p1 + term_p0);
    end
  end

  // Stage p1: accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1 <= '0;
    end else begin
      acc_p1 <= acc_d;
    end
  end

  assign acc = acc_p1;

endmodule

// File: rtl/iir_sos_cascade_mc.sv
// -----------------------------------------------------------------------------
// iir_sos_cascade_mc
// Multi-channel cascade of Direct Form I biquads sharing one multiplier.
// A sample is accepted in IDLE, each section takes five MAC cycles plus one
// SAT cycle (round half-up, saturate, shift history), then OUT presents the
// result. History (x1,x2,y1,y2) is kept per channel per section.
//
// Ports:
//   clk, resetn        : clock, asynchronous active-low reset
//   in_valid/in_ready  : sample handshake; in_ch channel, in_data sample
//   out_valid          : one-cycle pulse with out_ch / out_data
//   cfg_we/addr/data   : coefficient write, addr = 5*section + term
//   cfg_err            : one-cycle pulse on dropped write or bad channel
//   sat_cnt            : saturating count of clipping SAT cycles
//                        (present only when IIR_SAT_CNT_EN is defined)
//   state_clr          : zero all history (deferred until IDLE)
// Macro: IIR_SAT_CNT_EN enables the sat_cnt port and counter.
// -----------------------------------------------------------------------------
module iir_sos_cascade_mc
  import iir_pkg::*;
#(
  parameter int NDINT  = 3,
  parameter int NDFRAC = 22,
  parameter int NCINT  = 4,
  parameter int NCFRAC = 14,
  parameter int NSOS   = 2,
  parameter int NCH    = 2
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] in_ch,
  input  logic signed [NDINT+NDFRAC-1:0]           in_data,
  output logic                                     out_valid,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch,
  output logic signed [NDINT+NDFRAC-1:0]           out_data,
  input  logic                                     cfg_we,
  input  logic [$clog2(NSOS*5)-1:0]                cfg_addr,
  input  logic signed [NCINT+NCFRAC-1:0]           cfg_data,
  output logic                                     cfg_err,
`ifdef IIR_SAT_CNT_EN
  output logic [15:0]                              sat_cnt,
`endif
  input  logic                                     state_clr
);

  localparam int DW    = NDINT + NDFRAC;
  localparam int CW    = NCINT + NCFRAC;
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW    = (NSOS > 1) ? $clog2(NSOS) : 1;
  localparam int NCOEF = NSOS * NTERM;
  localparam int CIW   = $clog2(NCOEF);

  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(64'sd1 <<< (NCFRAC-1));
  localparam logic signed [ACC_W-1:0] DMAX = ACC_W'((64'sd1 <<< (DW-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] DMIN = ACC_W'(-(64'sd1 <<< (DW-1)));

  function automatic logic signed [ACC_W-1:0] round_half_up(input logic signed [ACC_W-1:0] a);
    return (a + RND) >>> NCFRAC;
  endfunction

  function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
    return (v > DMAX) || (v < DMIN);
  endfunction

  function automatic logic signed [DW-1:0] sat_data(input logic signed [ACC_W-1:0] v);
    if (v > DMAX) begin
      return DMAX[DW-1:0];
    end else if (v < DMIN) begin
      return DMIN[DW-1:0];
    end
    return v[DW-1:0];
  endfunction

  iir_state_e              state_q, state_d;
  logic [SW-1:0]           sec_q, sec_d;
  logic [2:0]              term_q, term_d;
  logic [CHW-1:0]          ch_q, ch_d;
  logic signed [DW-1:0]    smp_q, smp_d;
  logic                    rdy_q, rdy_d;
  logic                    clr_pend_q, clr_pend_d;
  logic                    out_valid_q, out_valid_d;
  logic [CHW-1:0]          out_ch_q, out_ch_d;
  logic signed [DW-1:0]    out_data_q, out_data_d;
  logic                    cfg_err_q, cfg_err_d;
  logic signed [CW-1:0]    coef_q [NCOEF];
  logic signed [CW-1:0]    coef_d [NCOEF];
  logic signed [DW-1:0]    x1_q [NCH][NSOS];
  logic signed [DW-1:0]    x1_d [NCH][NSOS];
  logic signed [DW-1:0]    x2_q [NCH][NSOS];
  logic signed [DW-1:0]    x2_d [NCH][NSOS];
  logic signed [DW-1:0]    y1_q [NCH][NSOS];
  logic signed [DW-1:0]    y1_d [NCH][NSOS];
  logic signed [DW-1:0]    y2_q [NCH][NSOS];
  logic signed [DW-1:0]    y2_d [NCH][NSOS];
`ifdef IIR_SAT_CNT_EN
  logic [15:0]             sat_cnt_q, sat_cnt_d;
`endif

  logic                    accept;
  logic                    ch_ok;
  logic                    clr_now;
  logic [CIW-1:0]          cidx;
  logic                    mac_en, mac_load, mac_sub;
  logic signed [DW-1:0]    mac_din;
  logic signed [CW-1:0]    mac_coef;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_rnd;
  logic signed [DW-1:0]    sec_y;
  logic                    clip;

  // A clear request (new or pending) blocks acceptance for its cycle.
  assign in_ready = rdy_q && !state_clr && !clr_pend_q;
  assign accept   = in_valid && in_ready;
  assign ch_ok    = int'(in_ch) < NCH;
  assign clr_now  = (state_q == ST_IDLE) && (state_clr || clr_pend_q);
  assign cidx     = CIW'(int'(sec_q) * NTERM + int'(term_q));

  // Stage p0: operand select for the shared multiplier
  always_comb begin
    mac_en   = (state_q == ST_MAC);
    mac_load = (term_q == TERM_B0);
    mac_sub  = (term_q >= TERM_A1);
    mac_coef = coef_q[cidx];
    case (term_q)
      TERM_B0: mac_din = smp_q;
      TERM_B1: mac_din = x1_q[ch_q][sec_q];
      TERM_B2: mac_din = x2_q[ch_q][sec_q];
      TERM_A1: mac_din = y1_q[ch_q][sec_q];
      TERM_A2: mac_din = y2_q[ch_q][sec_q];
      default: mac_din = '0;
    endcase
  end

  iir_mac #(
    .DATA_W (DW),
    .COEF_W (CW)
  ) u_mac (
    .clk   (clk),
    .rst_n (resetn),
    .en    (mac_en),
    .load  (mac_load),
    .sub   (mac_sub),
    .din   (mac_din),
    .coef  (mac_coef),
    .acc   (acc)
  );

  // Stage p1: section result from the completed accumulation
  assign acc_rnd = round_half_up(acc);
  assign sec_y   = sat_data(acc_rnd);
  assign clip    = sat_hit(acc_rnd);

  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    term_d      = term_q;
    ch_d        = ch_q;
    smp_d       = smp_q;
    rdy_d       = rdy_q;
    clr_pend_d  = clr_pend_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    cfg_err_d   = 1'b0;
    coef_d      = coef_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
`ifdef IIR_SAT_CNT_EN
    sat_cnt_d   = sat_cnt_q;
`endif

    // Coefficients may only change while idle and not racing an accept.
    if (cfg_we) begin
      if ((state_q == ST_IDLE) && !accept && (int'(cfg_addr) < NCOEF)) begin
        coef_d[cfg_addr] = cfg_data;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (clr_now) begin
      clr_pend_d = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        for (int s = 0; s < NSOS; s++) begin
          x1_d[c][s] = '0;
          x2_d[c][s] = '0;
          y1_d[c][s] = '0;
          y2_d[c][s] = '0;
        end
      end
`ifdef IIR_SAT_CNT_EN
      sat_cnt_d = '0;
`endif
    end else if (state_clr) begin
      clr_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        rdy_d = 1'b1;
        if (accept) begin
          if (ch_ok) begin
            state_d = ST_MAC;
            sec_d   = '0;
            term_d  = TERM_B0;
            ch_d    = in_ch;
            smp_d   = in_data;
            rdy_d   = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_MAC: begin
        if (term_q == TERM_A2) begin
          state_d = ST_SAT;
          term_d  = TERM_B0;
        end else begin
          term_d = term_q + 3'd1;
        end
      end
      ST_SAT: begin
        x2_d[ch_q][sec_q] = x1_q[ch_q][sec_q];
        x1_d[ch_q][sec_q] = smp_q;
        y2_d[ch_q][sec_q] = y1_q[ch_q][sec_q];
        y1_d[ch_q][sec_q] = sec_y;
        smp_d             = sec_y;
`ifdef IIR_SAT_CNT_EN
        if (clip && (sat_cnt_q != 16'hFFFF)) begin
          sat_cnt_d = sat_cnt_q + 16'd1;
        end
`endif
        if (sec_q == SW'(NSOS-1)) begin
          state_d = ST_OUT;
        end else begin
          state_d = ST_MAC;
          sec_d   = sec_q + SW'(1);
        end
      end
      ST_OUT: begin
        out_valid_d = 1'b1;
        out_ch_d    = ch_q;
        out_data_d  = smp_q;
        state_d     = ST_IDLE;
        rdy_d       = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      sec_q       <= '0;
      term_q      <= TERM_B0;
      ch_q        <= '0;
      smp_q       <= '0;
      rdy_q       <= 1'b0;
      clr_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      cfg_err_q   <= 1'b0;
      for (int i = 0; i < NCOEF; i++) begin
        coef_q[i] <= '0;
      end
      for (int c = 0; c < NCH; c++) begin
        for (int s = 0; s < NSOS; s++) begin
          x1_q[c][s] <= '0;
          x2_q[c][s] <= '0;
          y1_q[c][s] <= '0;
          y2_q[c][s] <= '0;
        end
      end
`ifdef IIR_SAT_CNT_EN
      sat_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      term_q      <= term_d;
      ch_q        <= ch_d;
      smp_q       <= smp_d;
      rdy_q       <= rdy_d;
      clr_pend_q  <= clr_pend_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      cfg_err_q   <= cfg_err_d;
      coef_q      <= coef_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
`ifdef IIR_SAT_CNT_EN
      sat_cnt_q   <= sat_cnt_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;
`ifdef IIR_SAT_CNT_EN
  assign sat_cnt   = sat_cnt_q;
`endif

endmodule

// File: tb/tb_iir_sos_cascade_mc.sv
// -----------------------------------------------------------------------------
// tb_iir_sos_cascade_mc
// Directed-plus-random bench for iir_sos_cascade_mc (NSOS=2, NCH=2) against an
// integer reference of the biquad cascade (per channel, per section history).
// Honors IIR_SAT_CNT_EN for the optional sat_cnt port.
// -----------------------------------------------------------------------------
module tb_iir_sos_cascade_mc;

  localparam int NSOS = 2;
  localparam int NCH  = 2;
  localparam int DW   = 25;
  localparam int CW   = 18;
  localparam int AW   = $clog2(NSOS*5);
  localparam int LAT  = 6*NSOS + 1;
  localparam longint ONE  = 64'sd1 <<< 22;
  localparam longint CONE = 64'sd1 <<< 14;
  localparam longint DMAX = (64'sd1 <<< 24) - 64'sd1;
  localparam longint DMIN = -(64'sd1 <<< 24);

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 in_valid;
  logic                 in_ready;
  logic [0:0]           in_ch;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic [0:0]           out_ch;
  logic signed [DW-1:0] out_data;
  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic signed [CW-1:0] cfg_data;
  logic                 cfg_err;
  logic                 state_clr;
`ifdef IIR_SAT_CNT_EN
  logic [15:0]          sat_cnt;
`endif

  always #5 clk = ~clk;

  iir_sos_cascade_mc #(
    .NDINT(3), .NDFRAC(22), .NCINT(4), .NCFRAC(14), .NSOS(NSOS), .NCH(NCH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
`ifdef IIR_SAT_CNT_EN
    .sat_cnt   (sat_cnt),
`endif
    .state_clr (state_clr)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  longint mc [NSOS*5];
  longint mx1 [NCH][NSOS];
  longint mx2 [NCH][NSOS];
  longint my1 [NCH][NSOS];
  longint my2 [NCH][NSOS];
  int     msat;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      for (int s = 0; s < NSOS; s++) begin
        mx1[c][s] = 0; mx2[c][s] = 0; my1[c][s] = 0; my2[c][s] = 0;
      end
    end
    msat = 0;
  endtask

  task automatic model_run(input int ch, input longint x, output longint y);
    longint xin, acc, r;
    xin = x;
    for (int s = 0; s < NSOS; s++) begin
      acc = mc[5*s]*xin + mc[5*s+1]*mx1[ch][s] + mc[5*s+2]*mx2[ch][s]
          - mc[5*s+3]*my1[ch][s] - mc[5*s+4]*my2[ch][s];
      r = (acc + (64'sd1 <<< 13)) >>> 14;
      if (r > DMAX) begin r = DMAX; msat++; end
      else if (r < DMIN) begin r = DMIN; msat++; end
      mx2[ch][s] = mx1[ch][s]; mx1[ch][s] = xin;
      my2[ch][s] = my1[ch][s]; my1[ch][s] = r;
      xin = r;
    end
    y = xin;
  endtask

  task automatic set_coef(input int idx, input longint v);
    mc[idx]  = v;
    cfg_we   = 1'b1;
    cfg_addr = AW'(idx);
    cfg_data = v[CW-1:0];
    @(posedge clk); #1;
    cfg_we   = 1'b0;
    check("cfg_write_err", 64'(cfg_err), 0);
  endtask

  task automatic load_sec(input int s, input longint b0, input longint b1, input longint b2,
                          input longint a1, input longint a2);
    set_coef(5*s,   b0);
    set_coef(5*s+1, b1);
    set_coef(5*s+2, b2);
    set_coef(5*s+3, a1);
    set_coef(5*s+4, a2);
  endtask

  task automatic launch(input int ch, input longint x);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 1);
    in_valid = 1'b1;
    in_ch    = 1'(ch);
    in_data  = x[DW-1:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic signed [63:0] y, output logic signed [63:0] oc, output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1; lat++;
      if (out_valid) break;
    end
    if (out_valid) begin
      y  = 64'($signed(out_data));
      oc = 64'(out_ch);
    end else begin
      check("out_valid_timeout", 64'(out_valid), 1);
      y  = 'x;
      oc = 'x;
    end
  endtask

  task automatic run_one(input string tag, input int ch, input longint x);
    longint exp;
    logic signed [63:0] y, oc;
    int lat;
    model_run(ch, x, exp);
    launch(ch, x);
    wait_out(y, oc, lat);
    check(tag, y, exp);
    check({tag, "_ch"}, oc, ch);
  endtask

  task automatic pulse_clr();
    state_clr = 1'b1;
    #1;
    check("clr_blocks_ready", 64'(in_ready), 0);
    @(posedge clk); #1;
    state_clr = 1'b0;
    model_clear();
  endtask

  task automatic load_butter();
    for (int s = 0; s < NSOS; s++) load_sec(s, 1600, 3199, 1600, -15447, 5461);
  endtask

  initial begin
    longint exp, x;
    logic signed [63:0] y, oc;
    int lat, seen;

    resetn = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; state_clr = 1'b0;
    for (int i = 0; i < NSOS*5; i++) mc[i] = 0;
    model_clear();
    repeat (3) @(posedge clk); #1;

    // Reset values
    check("rst_in_ready",  64'(in_ready), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_ch",    64'(out_ch), 0);
    check("rst_out_data",  64'($signed(out_data)), 0);
    check("rst_cfg_err",   64'(cfg_err), 0);
`ifdef IIR_SAT_CNT_EN
    check("rst_sat_cnt",   64'(sat_cnt), 0);
`endif
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 64'(in_ready), 1);

    // Pass-through sections: 0.5 in, 0.5 out, fixed latency
    load_sec(0, CONE, 0, 0, 0, 0);
    load_sec(1, CONE, 0, 0, 0, 0);
    model_run(0, ONE/2, exp);
    launch(0, ONE/2);
    wait_out(y, oc, lat);
    check("pass_data", y, ONE/2);
    check("pass_model", y, exp);
    check("pass_latency", lat, LAT);
    check("ready_at_out", 64'(in_ready), 1);
    @(posedge clk); #1;
    check("out_valid_pulse", 64'(out_valid), 0);

    // Butterworth impulse on ch0 interleaved with zeros on ch1
    pulse_clr();
    load_butter();
    for (int i = 0; i < 32; i++) begin
      run_one("bw_ch0", 0, (i == 0) ? ONE : 0);
      launch(1, 0);
      wait_out(y, oc, lat);
      check("bw_ch1_zero", y, 0);
      check("bw_ch1_ch", oc, 1);
      model_run(1, 0, exp);
    end

    // Random samples on random channels
    for (int i = 0; i < 40; i++) begin
      x = longint'($urandom_range(0, 1 << 23)) - (64'sd1 <<< 22);
      run_one("rand_bw", int'($urandom_range(0, NCH-1)), x);
    end

    // Random coefficient sets (may be unstable, exercising saturation)
    for (int i = 0; i < NSOS*5; i++) set_coef(i, longint'($urandom_range(0, 1 << 17)) - (64'sd1 <<< 16));
    for (int i = 0; i < 16; i++) begin
      x = longint'($urandom_range(0, 1 << 23)) - (64'sd1 <<< 22);
      run_one("rand_coef", int'($urandom_range(0, NCH-1)), x);
    end

    // Saturation: gain 4.0 on 3.9 clips to the data range
    pulse_clr();
    load_sec(0, 4*CONE, 0, 0, 0, 0);
    load_sec(1, CONE, 0, 0, 0, 0);
    x = 16357786;
    model_run(0, x, exp);
    launch(0, x);
    wait_out(y, oc, lat);
    check("sat_pos", y, DMAX);
    check("sat_pos_model", y, exp);
    model_run(1, -x, exp);
    launch(1, -x);
    wait_out(y, oc, lat);
    check("sat_neg", y, DMIN);
    check("sat_neg_model", y, exp);
`ifdef IIR_SAT_CNT_EN
    check("sat_cnt", 64'(sat_cnt), msat);
`endif

    // Configuration errors
    cfg_we = 1'b1; cfg_addr = AW'(NSOS*5); cfg_data = 18'sd1000;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("cfg_bad_addr_err", 64'(cfg_err), 1);
    @(posedge clk); #1;
    check("cfg_err_pulse", 64'(cfg_err), 0);

    model_run(0, ONE/2, exp);
    launch(0, ONE/2);
    cfg_we = 1'b1; cfg_addr = '0; cfg_data = 18'sd1234;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("cfg_in_mac_err", 64'(cfg_err), 1);
    wait_out(y, oc, lat);
    check("cfg_in_mac_coef_kept", y, exp);

    model_run(1, ONE/4, exp);
    cfg_we = 1'b1; cfg_addr = '0; cfg_data = 18'sd77;
    launch(1, ONE/4);
    cfg_we = 1'b0;
    check("cfg_with_accept_err", 64'(cfg_err), 1);
    wait_out(y, oc, lat);
    check("cfg_with_accept_coef_kept", y, exp);

    // Clear requested mid-computation takes effect on return to IDLE
    pulse_clr();
    load_butter();
    run_one("hist_a", 0, ONE);
    run_one("hist_b", 0, ONE/2);
    model_run(0, ONE/4, exp);
    launch(0, ONE/4);
    state_clr = 1'b1;
    @(posedge clk); #1;
    state_clr = 1'b0;
    wait_out(y, oc, lat);
    check("pend_clr_sample", y, exp);
    check("pend_clr_ready", 64'(in_ready), 0);
    @(posedge clk); #1;
    model_clear();
    check("pend_clr_ready_back", 64'(in_ready), 1);
    run_one("after_clr", 0, ONE);

    // Reset during the MAC phase abandons the sample
    launch(0, ONE);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 3) resetn = 1'b1;
      if (out_valid) seen++;
    end
    check("rst_mid_no_out", seen, 0);
    for (int i = 0; i < NSOS*5; i++) mc[i] = 0;
    model_clear();
    run_one("coef_zero_after_rst", 0, ONE);
    load_butter();
    for (int i = 0; i < 6; i++) run_one("from_zero", 0, (i == 0) ? ONE : 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
